// File: rtl/imm_expand_unit.sv
// imm_expand_unit: multi-cycle immediate expander for the CalcuTEC decode stage.
// Turns a raw instruction immediate into a DATA_W operand. Three modes are
// supported: data-processing rotate, memory offset zero-extend and branch
// offset sign-extend-and-shift. The data-processing rotate runs iteratively,
// ROT_STEP bits per cycle. Valid/ready handshakes are used on both the input
// and the output side.
module imm_expand_unit #(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 24,
    parameter int ROT_STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        imm_src,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data,
    output logic              carry_out,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_HOLD
    } state_t;

    // The remaining rotation never exceeds 30, so clamping the per-cycle step
    // to 32 changes nothing. The clamp keeps every step quantity in 7 bits.
    localparam logic [6:0] STEP_MAX = 7'((ROT_STEP > 32) ? 32 : ROT_STEP);
    localparam logic [6:0] WIDTH7   = 7'(DATA_W);

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic                r_carry;
    logic                r_err;
    logic [4:0]          r_rem;

    logic [6:0]          w_rem_ext;
    logic [6:0]          w_step;
    logic [6:0]          w_amt;
    logic [DATA_W-1:0]   w_rot;
    logic [4:0]          w_rem_next;

    logic [DATA_W-1:0]   w_dp_data;
    logic [DATA_W-1:0]   w_mem_data;
    logic [DATA_W-1:0]   w_br_data;
    logic [4:0]          w_dp_rem;
    logic                w_unused_imm;

    // Per-mode expansions of the immediate, taken straight from the request fields.
    assign w_dp_data    = {{(DATA_W-8){1'b0}}, imm[7:0]};
    assign w_mem_data   = {{(DATA_W-12){1'b0}}, imm[11:0]};
    assign w_br_data    = {{(DATA_W-24){imm[23]}}, imm[23:0]} << 2;
    assign w_dp_rem     = {imm[11:8], 1'b0};
    assign w_unused_imm = ^imm;

    // One rotate step: take min(ROT_STEP, remaining) bits and rotate right by that amount.
    // When DATA_W is narrower than the step, the step is reduced modulo DATA_W.
    always_comb begin
        w_rem_ext  = {2'b00, r_rem};
        w_step     = (w_rem_ext < STEP_MAX) ? w_rem_ext : STEP_MAX;
        w_amt      = (w_step >= WIDTH7) ? (w_step - WIDTH7) : w_step;
        w_rot      = (r_data >> w_amt) | (r_data << (WIDTH7 - w_amt));
        w_rem_next = 5'(w_rem_ext - w_step);
    end

    // Control FSM and result registers. Reset drops any rotation or held
    // result that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_err   <= 1'b0;
                        r_carry <= carry_in;
                        case (imm_src)
                            2'd0: begin
                                r_data  <= w_dp_data;
                                r_rem   <= w_dp_rem;
                                r_state <= (imm[11:8] == 4'd0) ? S_HOLD : S_ROT;
                            end
                            2'd1: begin
                                r_data  <= w_mem_data;
                                r_state <= S_HOLD;
                            end
                            2'd2: begin
                                r_data  <= w_br_data;
                                r_state <= S_HOLD;
                            end
                            default: begin
                                r_data  <= '1;
                                r_err   <= 1'b1;
                                r_state <= S_HOLD;
                            end
                        endcase
                    end
                end
                S_ROT: begin
                    r_data <= w_rot;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == 5'd0) begin
                        r_carry <= w_rot[DATA_W-1];
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign data      = r_data;
    assign carry_out = r_carry;
    assign err       = r_err;

endmodule

// File: tb/tb_imm_expand_unit.sv
// tb_imm_expand_unit: directed self-checking bench for imm_expand_unit.
// The main instance uses ROT_STEP=2. Four extra instances with ROT_STEP
// values of 1, 2, 8 and 32 are used for the rotate sweep.
module tb_imm_expand_unit;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [23:0] immIn;
    logic [1:0]  immSrc;
    logic        carryIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] dataOut;
    logic        carryOut;
    logic        errOut;

    logic        swInValid;
    logic [23:0] swImm;
    logic        swCarryIn;
    logic        swOutReady;
    logic [3:0]  swInReady;
    logic [3:0]  swOutValid;
    logic [31:0] swData [4];
    logic [3:0]  swCarryOut;
    logic [3:0]  swErr;

    int vecCount;
    int missCount;

    imm_expand_unit #(.DATA_W(32), .IMM_W(24), .ROT_STEP(2)) uDut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .imm       (immIn),
        .imm_src   (immSrc),
        .carry_in  (carryIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .data      (dataOut),
        .carry_out (carryOut),
        .err       (errOut)
    );

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gSweep
            localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
            imm_expand_unit #(.DATA_W(32), .IMM_W(24), .ROT_STEP(ST)) uSweep (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (swInValid),
                .in_ready  (swInReady[g]),
                .imm       (swImm),
                .imm_src   (2'd0),
                .carry_in  (swCarryIn),
                .out_valid (swOutValid[g]),
                .out_ready (swOutReady),
                .data      (swData[g]),
                .carry_out (swCarryOut[g]),
                .err       (swErr[g])
            );
        end
    endgenerate

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rorRef(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic int stepOf(input int idx);
        int steps [4] = '{1, 2, 8, 32};
        return steps[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to the main instance. Returns 1 ns after the accept
    // edge. The fields are then scrambled so that any late dependence on them shows up.
    task automatic applyStimulus(input logic [1:0] src, input logic [23:0] imm, input logic cin);
        inValid = 1'b1;
        immSrc  = src;
        immIn   = imm;
        carryIn = cin;
        tick();
        inValid = 1'b0;
        immIn   = ~imm;
        immSrc  = ~src;
        carryIn = ~cin;
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        while (!outValid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    // Directed sequence: reset, the individual modes, backpressure, reset during a rotation, and the sweep.
    initial begin
        int lat;
        int ones;
        logic [31:0] held;
        int gotLat [4];
        vecCount   = 0;
        missCount  = 0;
        rst_n      = 1'b0;
        inValid    = 1'b0;
        immIn      = '0;
        immSrc     = '0;
        carryIn    = 1'b0;
        outReady   = 1'b0;
        swInValid  = 1'b0;
        swImm      = '0;
        swCarryIn  = 1'b0;
        swOutReady = 1'b0;
        tick();
        tick();
        checkOutput("rst in_ready", 64'(inReady), 64'd1);
        checkOutput("rst out_valid", 64'(outValid), 64'd0);
        checkOutput("rst data", 64'(dataOut), 64'd0);
        checkOutput("rst carry", 64'(carryOut), 64'd0);
        checkOutput("rst err", 64'(errOut), 64'd0);
        rst_n = 1'b1;
        tick();

        // DP, rotate 0
        applyStimulus(2'd0, 24'h0000FF, 1'b1);
        waitResult(lat);
        checkOutput("t1 lat", 64'(lat), 64'd1);
        checkOutput("t1 data", 64'(dataOut), 64'h000000FF);
        checkOutput("t1 carry", 64'(carryOut), 64'd1);
        checkOutput("t1 err", 64'(errOut), 64'd0);
        releaseResult();
        checkOutput("t1 valid drop", 64'(outValid), 64'd0);
        checkOutput("t1 ready back", 64'(inReady), 64'd1);

        // DP, rotate right by 8
        applyStimulus(2'd0, 24'h0004FF, 1'b0);
        waitResult(lat);
        checkOutput("t2 lat", 64'(lat), 64'd5);
        checkOutput("t2 data", 64'(dataOut), 64'hFF000000);
        checkOutput("t2 carry", 64'(carryOut), 64'd1);
        releaseResult();

        // Illegal source, then MEM and BR
        applyStimulus(2'd3, 24'h123456, 1'b1);
        waitResult(lat);
        checkOutput("ill lat", 64'(lat), 64'd1);
        checkOutput("ill data", 64'(dataOut), 64'hFFFFFFFF);
        checkOutput("ill err", 64'(errOut), 64'd1);
        checkOutput("ill carry", 64'(carryOut), 64'd1);
        releaseResult();
        applyStimulus(2'd1, 24'h00FABC, 1'b0);
        waitResult(lat);
        checkOutput("mem lat", 64'(lat), 64'd1);
        checkOutput("mem data", 64'(dataOut), 64'h00000ABC);
        checkOutput("mem err", 64'(errOut), 64'd0);
        checkOutput("mem carry", 64'(carryOut), 64'd0);
        releaseResult();
        applyStimulus(2'd2, 24'hFFFFFE, 1'b1);
        waitResult(lat);
        checkOutput("br data", 64'(dataOut), 64'hFFFFFFF8);
        checkOutput("br carry", 64'(carryOut), 64'd1);
        releaseResult();
        applyStimulus(2'd2, 24'h400001, 1'b0);
        waitResult(lat);
        checkOutput("br pos data", 64'(dataOut), 64'h01000004);
        releaseResult();

        // Backpressure: 0xF3 rotated right by 4 is held while out_ready stays low
        applyStimulus(2'd0, 24'h0002F3, 1'b1);
        waitResult(lat);
        checkOutput("t4 lat", 64'(lat), 64'd3);
        held = 32'h3000000F;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("t4 hold%0d data", c), 64'(dataOut), 64'(held));
            checkOutput($sformatf("t4 hold%0d valid", c), 64'(outValid), 64'd1);
            checkOutput($sformatf("t4 hold%0d in_ready", c), 64'(inReady), 64'd0);
            tick();
        end
        checkOutput("t4 carry", 64'(carryOut), 64'd0);
        releaseResult();
        checkOutput("t4 idle valid", 64'(outValid), 64'd0);
        checkOutput("t4 idle ready", 64'(inReady), 64'd1);

        // Reset during the second ROT cycle
        applyStimulus(2'd0, 24'h0004FF, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("t5 valid", 64'(outValid), 64'd0);
        checkOutput("t5 data", 64'(dataOut), 64'd0);
        checkOutput("t5 in_ready", 64'(inReady), 64'd1);
        rst_n = 1'b1;
        ones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (outValid) ones++;
        end
        checkOutput("t5 no stale", 64'(ones), 64'd0);

        // Sweep over ROT_STEP values and every rotate field value
        for (int rot = 0; rot < 16; rot++) begin
            swImm      = 24'(((rot * 7 + 3) & 255) | (rot << 8)) | 24'hA5F000;
            swCarryIn  = rot[0];
            swInValid  = 1'b1;
            held       = rorRef({24'h0, swImm[7:0]}, 2 * rot);
            tick();
            swInValid  = 1'b0;
            swImm      = ~swImm;
            for (int k = 0; k < 4; k++) gotLat[k] = 0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                for (int k = 0; k < 4; k++) if (gotLat[k] == 0 && swOutValid[k]) gotLat[k] = cyc;
                if (gotLat[0] != 0 && gotLat[1] != 0 && gotLat[2] != 0 && gotLat[3] != 0) break;
                tick();
            end
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("sw s%0d r%0d data", stepOf(k), rot), 64'(swData[k]), 64'(held));
                checkOutput($sformatf("sw s%0d r%0d carry", stepOf(k), rot), 64'(swCarryOut[k]),
                            64'((rot == 0) ? (rot % 2 == 1) : held[31]));
                checkOutput($sformatf("sw s%0d r%0d lat", stepOf(k), rot), 64'(gotLat[k]),
                            64'((rot == 0) ? 1 : 1 + (2 * rot + stepOf(k) - 1) / stepOf(k)));
            end
            swOutReady = 1'b1;
            tick();
            swOutReady = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
